// File: rtl/opcode_enc32_rr.sv
// opcode_enc32_rr: collects one-hot request strobes into a pending set and
// emits each outstanding line as a binary code over a valid/ready handshake.
// Lines are served round-robin, starting at the line after the last grant.
module opcode_enc32_rr #(
  parameter int NUM_IN = 32,
  parameter int CODE_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req_in,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [NUM_IN-1:0] pending,
  output logic              overflow,
  output logic              busy
);

  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] win;
  logic [CODE_W-1:0] idx;
  logic              found;
  logic              stage_free;
  logic              grant;
  logic [NUM_IN-1:0] grant_mask;

  // Round-robin search over the registered pending set, starting at ptr.
  // ptr is CODE_W bits wide, so ptr + i wraps modulo NUM_IN on its own.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = ptr + CODE_W'(i);
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign stage_free = !code_valid || code_ready;
  assign grant      = stage_free && found;
  assign grant_mask = grant ? (NUM_IN'(1) << win) : '0;
  assign busy       = (|pending) || code_valid;

  // Pending set, output stage, overflow pulse and rr pointer.
  // A new strobe on the line being granted re-arms it rather than being lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
      ptr        <= '0;
    end else begin
      pending  <= (pending & ~grant_mask) | req_in;
      overflow <= |(req_in & pending & ~grant_mask);
      if (grant) begin
        code_out   <= win;
        code_valid <= 1'b1;
        ptr        <= win + CODE_W'(1);
      end else if (stage_free) begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opcode_enc32_rr.sv
// Bench for opcode_enc32_rr: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_opcode_enc32_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_in = '0;
  logic        code_ready = 1'b0;
  logic [4:0]  code_out;
  logic        code_valid;
  logic [31:0] pending;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pend = '0;
  int          m_ptr = 0;
  logic [4:0]  m_code = '0;
  bit          m_valid = 1'b0;
  bit          m_ovf = 1'b0;
  bit          cmp_en = 1'b0;

  opcode_enc32_rr #(.NUM_IN(32), .CODE_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .code_out(code_out),
    .code_valid(code_valid), .code_ready(code_ready), .pending(pending),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, written from the rules:
  // pick the first pending line at or after ptr (mod 32) if the stage is free.
  task automatic model_edge(input logic [31:0] r, input bit rdy, input bit rstn);
    int w;
    bit free;
    logic [31:0] np;
    if (!rstn) begin
      m_pend = '0; m_ptr = 0; m_code = '0; m_valid = 0; m_ovf = 0;
      return;
    end
    free = !m_valid || rdy;
    w = -1;
    if (free && m_pend != 0)
      for (int k = 0; k < 32; k++)
        if (w < 0 && m_pend[(m_ptr + k) % 32]) w = (m_ptr + k) % 32;
    np = r;
    m_ovf = 0;
    for (int i = 0; i < 32; i++)
      if (m_pend[i] && i != w) begin
        np[i] = 1'b1;
        if (r[i]) m_ovf = 1;
      end
    m_pend = np;
    if (w >= 0) begin
      m_code = 5'(w); m_valid = 1; m_ptr = (w + 1) % 32;
    end else if (free) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input logic [31:0] r, input bit rdy, input bit rstn);
    req_in = r; code_ready = rdy; rst_n = rstn;
    @(posedge clk);
    model_edge(r, rdy, rstn);
    @(negedge clk);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.code_valid", 32'(code_valid), 32'(m_valid));
      chk("m.code_out",   32'(code_out),   32'(m_code));
      chk("m.pending",    pending,         m_pend);
      chk("m.overflow",   32'(overflow),   32'(m_ovf));
      chk("m.busy",       32'(busy),       32'((m_pend != 0) || m_valid));
    end
  end

  initial begin
    int n;
    int ovf_cnt;
    logic [31:0] r;
    cmp_en = 1'b1;

    // 1. reset with all requests asserted
    for (int i = 0; i < 2; i++) begin
      step(32'hFFFF_FFFF, 1, 0);
      chk("rst.pending", pending, 32'h0);
      chk("rst.valid", 32'(code_valid), 32'h0);
      chk("rst.code", 32'(code_out), 32'h0);
      chk("rst.ovf", 32'(overflow), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
    end
    step(32'hFFFF_FFFF, 1, 1);
    chk("rel.pending", pending, 32'hFFFF_FFFF);
    chk("rel.valid", 32'(code_valid), 32'h0);
    for (int i = 0; i < 32; i++) begin
      step(32'h0, 1, 1);
      chk("drain.code", 32'(code_out), 32'(i));
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(32'h0, 1, 1); n++; end
    chk("drain.busy", 32'(busy), 32'h0);
    chk("drain.ptr_model", 32'(m_ptr), 32'h0);

    // 2. single request on line 5
    step(32'h0000_0020, 1, 1);
    chk("single.pending", pending, 32'h20);
    chk("single.valid0", 32'(code_valid), 32'h0);
    step(32'h0, 1, 1);
    chk("single.valid1", 32'(code_valid), 32'h1);
    chk("single.code", 32'(code_out), 32'h5);
    step(32'h0, 1, 1);
    chk("single.valid2", 32'(code_valid), 32'h0);
    chk("single.pending2", pending, 32'h0);

    // 3. burst of three with ptr brought back to 0 via line 31
    step(32'h8000_0000, 1, 1);
    step(32'h0, 1, 1);
    step(32'h0, 1, 1);
    chk("burst.ptr0_model", 32'(m_ptr), 32'h0);
    step(32'h8000_4001, 1, 1);
    step(32'h0, 1, 1); chk("burst.c0", 32'(code_out), 32'd0);
    step(32'h0, 1, 1); chk("burst.c14", 32'(code_out), 32'd14);
    step(32'h0, 1, 1); chk("burst.c31", 32'(code_out), 32'd31);
    chk("burst.valid", 32'(code_valid), 32'h1);
    step(32'h0, 1, 1);
    chk("burst.busy", 32'(busy), 32'h0);
    chk("burst.ptr_model", 32'(m_ptr), 32'h0);

    // 4. round-robin wrap from ptr=10
    step(32'h0000_0200, 1, 1);
    step(32'h0, 1, 1);
    chk("rr.c9", 32'(code_out), 32'd9);
    step((32'h1 << 3) | (32'h1 << 20), 1, 1);
    step(32'h0, 1, 1); chk("rr.c20", 32'(code_out), 32'd20);
    chk("rr.ptr21_model", 32'(m_ptr), 32'd21);
    step(32'h0, 1, 1); chk("rr.c3", 32'(code_out), 32'd3);
    chk("rr.ptr4_model", 32'(m_ptr), 32'd4);
    step(32'h0, 1, 1);
    chk("rr.idle", 32'(code_valid), 32'h0);

    // 5. backpressure with duplicate request on line 9
    step(32'h0000_0080, 1, 1);
    step(32'h0, 0, 1);
    chk("bp.c7", 32'(code_out), 32'd7);
    ovf_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step((i == 0 || i == 2) ? 32'h0000_0200 : 32'h0, 0, 1);
      chk("bp.hold_code", 32'(code_out), 32'd7);
      chk("bp.hold_valid", 32'(code_valid), 32'h1);
      if (overflow === 1'b1) ovf_cnt++;
      if (i == 2) chk("bp.ovf_pulse", 32'(overflow), 32'h1);
    end
    chk("bp.pend9", 32'(pending[9]), 32'h1);
    chk("bp.ovf_count", 32'(ovf_cnt), 32'd1);
    step(32'h0, 1, 1);
    chk("bp.c9", 32'(code_out), 32'd9);
    step(32'h0, 1, 1);
    chk("bp.once", 32'(code_valid), 32'h0);

    // 6. re-request on the grant edge
    step(32'h0000_0004, 1, 1);
    step(32'h0000_0004, 1, 1);
    chk("rereq.c2", 32'(code_out), 32'd2);
    chk("rereq.pend", pending, 32'h4);
    chk("rereq.ovf", 32'(overflow), 32'h0);
    step(32'h0, 1, 1);
    chk("rereq.c2b", 32'(code_out), 32'd2);
    chk("rereq.valid", 32'(code_valid), 32'h1);
    step(32'h0, 1, 1);
    chk("rereq.idle", 32'(code_valid), 32'h0);

    // randomized traffic with occasional mid-run reset
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 32'h1 << $urandom_range(0, 31);
        2: r = $urandom & $urandom & $urandom;
        default: r = $urandom & $urandom;
      endcase
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 249) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opcode_enc32_rr.md
Name: opcode_enc32_rr

Overview:
- Sequential inverse of the 5-to-32 one-hot opcode decoder: collects single-line request strobes on 32 one-hot lines.
- Queues them in a pending register and emits each as a 5-bit binary code over a valid/ready handshake.
- Round-robin arbitration among pending lines; output is registered so a downstream decoder sees stable codes.

Parameters:
- NUM_IN, 32, number of one-hot request lines; must equal 2**CODE_W.
- CODE_W, 5, width of the encoded output code.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_in  in  NUM_IN  request strobes, any number of bits per cycle, sampled every edge
- code_out  out  CODE_W  encoded index of the granted line
- code_valid  out  1  code_out holds a valid code
- code_ready  in  1  consumer accepts code_out when code_valid && code_ready
- pending  out  NUM_IN  registered set of outstanding requests
- overflow  out  1  one-cycle pulse: a request was coalesced (lost duplicate)
- busy  out  1  |pending || code_valid

Behaviour:
- Reset: one clock, synchronous, active low. Sampled with rst_n=0, it applies to that edge and mid-operation discards all state; req_in is ignored on that edge.
  - pending=0, code_out=0, code_valid=0, overflow=0, rr pointer ptr=0.
- Output stage free when !code_valid || code_ready.
- Grant selection is combinational from the registered pending only, not from req_in.
  - Search starts at index ptr and increments mod NUM_IN; the first set bit is the winner w.
  - A grant occurs when the output stage is free and pending != 0.
- On a grant edge:
  - code_out <= w, code_valid <= 1.
  - ptr <= (w+1) mod NUM_IN, with wrap from 31 to 0.
  - pending bit w is cleared unless req_in[w] is set that edge.
- Free stage and pending==0: code_valid <= 0, code_out holds its last value.
- Stalled (code_valid && !code_ready): code_out, code_valid and ptr hold; no grant.
- Pending update every edge: pending <= (pending & ~grant_mask) | req_in.
  - Set wins over clear for the same bit.
- Overflow <= 1 for one cycle if any req_in[i] is set while pending[i] is set and bit i is not being granted that edge.
  - Duplicates coalesce into one pending bit; no counting.
- Latency:
  - req_in[i] sampled at edge k sets pending[i] after edge k.
  - Earliest code_valid with code i is after edge k+1, given the stage is free and i wins arbitration.
- Throughput: one code per cycle when code_ready is held high.
- Independent of handshake: a request for the line currently displayed on code_out is a new request.
- Width rules: code_out is zero-extended index, no sign; ptr is CODE_W bits with natural wrap.

Test Plan:
1. Reset:
   - Stimulus: rst_n=0 for 2 edges with req_in=32'hFFFF_FFFF, code_ready=1.
   - Response: pending=0, code_valid=0, code_out=0, overflow=0, busy=0 throughout. First edge after release sets pending=32'hFFFF_FFFF.
2. Single request:
   - Stimulus: req_in=32'h0000_0020 at edge k, code_ready=1.
   - Response: pending=32'h20 after k; code_valid=1, code_out=5'd5 after k+1; code_valid=0, pending=0 after k+2.
3. Multi-request burst:
   - Stimulus: req_in=32'h8000_4001 in one cycle, ptr=0, code_ready=1.
   - Response: codes 0, 14, 31 on three consecutive cycles; ptr ends at 0 (wrap); busy drops after the third accept.
4. Round-robin wrap:
   - Stimulus: ptr=10, pending bits 3 and 20.
   - Response: code 20 emitted before code 3; ptr goes 21, then 4.
5. Backpressure and overflow:
   - Stimulus: code_out=7 valid with code_ready=0 for 5 cycles; req_in[9] pulsed on 2 separate cycles during the stall.
   - Response: code_out stays 7, code_valid stays 1; pending[9]=1; exactly one overflow pulse on the second req_in[9]; code 9 emitted once after ready returns.
6. Simultaneous grant and re-request:
   - Stimulus: pending=32'h4 only, stage free, req_in[2]=1 on the grant edge.
   - Response: code 2 emitted, pending[2] stays 1, overflow=0; code 2 emitted again on the next cycle with ready=1.
